// File: rtl/dot1d_stream.sv
// -----------------------------------------------------------------------------
// mac1d
//   Combinational fixed-point multiply-add: y = m * x + b.
//   The product is exact, binary points are aligned, and the add is done at full
//   precision with one guard integer bit. The result is then cut to the Y format.
//   Excess fraction bits are dropped, which floors toward -inf. Excess integer
//   bits are discarded, which wraps in two's complement.
//   Ports:
//     m  signed (IW_M, QW_M) multiplicand
//     x  signed (IW_X, QW_X) multiplier
//     b  signed (IW_Y, QW_Y) addend
//     y  signed (IW_Y, QW_Y) result
// -----------------------------------------------------------------------------
module mac1d #(
   parameter int IW_M = 4,
   parameter int QW_M = 8,
   parameter int IW_X = 4,
   parameter int QW_X = 8,
   parameter int IW_Y = 4,
   parameter int QW_Y = 8
) (
   input  logic [IW_M+QW_M-1:0] m,
   input  logic [IW_X+QW_X-1:0] x,
   input  logic [IW_Y+QW_Y-1:0] b,
   output logic [IW_Y+QW_Y-1:0] y
);

   localparam int WM = IW_M + QW_M;
   localparam int WX = IW_X + QW_X;
   localparam int WY = IW_Y + QW_Y;
   localparam int WP = WM + WX;             // exact product width
   localparam int QP = QW_M + QW_X;         // product fraction bits
   localparam int IP = IW_M + IW_X;         // product integer bits
   localparam int QF = (QP > QW_Y) ? QP : QW_Y;
   localparam int IS = ((IP > IW_Y) ? IP : IW_Y) + 1;  // +1 guard bit
   localparam int WS = IS + QF;             // aligned sum width

   logic signed [WP-1:0] m_ext;
   logic signed [WP-1:0] x_ext;
   logic signed [WP-1:0] prod;
   logic [WS-1:0]        p_al;
   logic [WS-1:0]        b_al;
   logic [WS-1:0]        sum;
   logic                 unused_sum;

   // Sign-extend both operands to the product width so the multiply is exact.
   assign m_ext = {{WX{m[WM-1]}}, m};
   assign x_ext = {{WM{x[WX-1]}}, x};
   assign prod  = m_ext * x_ext;

   // Align both terms to QF fraction bits. The operand with fewer fraction
   // bits gets zeros appended on the right.
   assign p_al = {{(WS-WP){prod[WP-1]}}, prod} << (QF - QP);
   assign b_al = {{(WS-WY){b[WY-1]}}, b} << (QF - QW_Y);
   assign sum  = p_al + b_al;

   // Taking a window of the two's-complement sum drops the low fraction bits,
   // which floors toward -inf. It also drops the high integer bits, which wraps.
   assign y = sum[QF-QW_Y +: WY];

   // Bits outside the window are intentionally discarded.
   assign unused_sum = ^sum;

endmodule

// -----------------------------------------------------------------------------
// dot1d_stream
//   Streaming dot-product sequencer. It accepts LEN (m, x) beats over a
//   valid/ready handshake and produces y = bias + sum(m_i * x_i), one result
//   per vector. The mac1d stage is reused on every beat: its output becomes the
//   next addend, so the Y-format rounding and wrap are applied beat by beat.
//   Ports:
//     clk_in     clock
//     rst_in     synchronous active-high reset
//     bias       signed Y-format bias, sampled on the first beat of a vector
//     in_m       signed element of m
//     in_x       signed element of x
//     in_valid   in_m/in_x valid
//     in_ready   block accepts a beat (high only while accumulating)
//     out_y      registered signed dot-product result
//     out_valid  out_y valid (high only while holding a result)
//     out_ready  downstream accepts out_y
// -----------------------------------------------------------------------------
module dot1d_stream #(
   parameter int IW_M = 4,
   parameter int QW_M = 8,
   parameter int IW_X = 4,
   parameter int QW_X = 8,
   parameter int IW_Y = 4,
   parameter int QW_Y = 8,
   parameter int LEN  = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [IW_Y+QW_Y-1:0] bias,
   input  logic [IW_M+QW_M-1:0] in_m,
   input  logic [IW_X+QW_X-1:0] in_x,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [IW_Y+QW_Y-1:0] out_y,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int WY = IW_Y + QW_Y;
   localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);

   localparam logic ACC = 1'b0;   // accepting beats
   localparam logic OUT = 1'b1;   // holding a result for downstream

   logic          state;
   logic [CW-1:0] count;
   logic [WY-1:0] acc;
   logic [WY-1:0] mac_b;
   logic [WY-1:0] mac_y;
   logic          beat;

   // The first beat of a vector starts from the bias, not from a stale acc.
   assign mac_b = (count == '0) ? bias : acc;

   mac1d #(
      .IW_M(IW_M), .QW_M(QW_M),
      .IW_X(IW_X), .QW_X(QW_X),
      .IW_Y(IW_Y), .QW_Y(QW_Y)
   ) u_mac (
      .m(in_m),
      .x(in_x),
      .b(mac_b),
      .y(mac_y)
   );

   // Both handshake flags decode from the state register alone. This keeps the
   // ready/valid paths free of combinational loops through neighbouring blocks.
   assign in_ready  = (state == ACC);
   assign out_valid = (state == OUT);
   assign beat      = in_valid && in_ready;

   always_ff @(posedge clk_in) begin
      // NOTE: state registers use non-blocking assignments, so every register
      // samples the values from before this edge, whatever the statement order.
      if (rst_in) begin
         state <= ACC;
         count <= '0;
         acc   <= '0;
         out_y <= '0;
      end else begin
         case (state)
            ACC: begin
               if (beat) begin
                  acc <= mac_y;
                  if (count == LAST) begin
                     out_y <= mac_y;
                     count <= '0;
                     state <= OUT;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  state <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule
